// File: rtl/universal_shift_register.sv
// Multi-mode shift register with frame counter.
// Hold, shift, rotate, load and clear, chosen per cycle by mode.
module universal_shift_register #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    localparam int                   CNT_W       = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            mode,
    input  logic                  ser_in_msb,
    input  logic                  ser_in_lsb,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ser_out,
    output logic [CNT_W-1:0]      bit_count,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        HOLD    = 3'b000,
        SHIFT_R = 3'b001,
        SHIFT_L = 3'b010,
        ROT_R   = 3'b011,
        ROT_L   = 3'b100,
        LOAD    = 3'b101,
        CLEAR   = 3'b110,
        RSVD    = 3'b111
    } mode_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    mode_t op;
    logic  is_shift;
    logic  is_abort;

    assign op = mode_t'(mode);

    // Classify the current mode for the frame counter.
    always_comb begin
        is_shift = 1'b0;
        is_abort = 1'b0;
        unique case (op)
            SHIFT_R, SHIFT_L: is_shift = 1'b1;
            LOAD, CLEAR:      is_abort = 1'b1;
            default:          ;
        endcase
    end

    // Register contents and the last bit shifted out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_VALUE;
            ser_out  <= 1'b0;
        end else begin
            unique case (op)
                SHIFT_R: begin
                    data_out <= {ser_in_msb, data_out[DATA_WIDTH-1:1]};
                    ser_out  <= data_out[0];
                end
                SHIFT_L: begin
                    data_out <= {data_out[DATA_WIDTH-2:0], ser_in_lsb};
                    ser_out  <= data_out[DATA_WIDTH-1];
                end
                ROT_R:
                    data_out <= {data_out[0], data_out[DATA_WIDTH-1:1]};
                ROT_L:
                    data_out <= {data_out[DATA_WIDTH-2:0],
                                 data_out[DATA_WIDTH-1]};
                LOAD:    data_out <= load_data;
                CLEAR:   data_out <= '0;
                default: ;
            endcase
        end
    end

    // Count shifts; pulse frame_done when a full word has gone through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (is_shift) begin
                if (bit_count == LAST) begin
                    bit_count  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_count <= bit_count + CNT_W'(1);
                end
            end else if (is_abort) begin
                bit_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register.
// W=8, RESET_VALUE=0.
module tb_universal_shift_register;

    localparam int W = 8;
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SR   = 3'b001;
    localparam logic [2:0] M_SL   = 3'b010;
    localparam logic [2:0] M_RR   = 3'b011;
    localparam logic [2:0] M_RL   = 3'b100;
    localparam logic [2:0] M_LD   = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;
    localparam logic [2:0] M_RSV  = 3'b111;

    logic          clk;
    logic          reset;
    logic [2:0]    mode;
    logic          ser_in_msb;
    logic          ser_in_lsb;
    logic [W-1:0]  load_data;
    logic [W-1:0]  data_out;
    logic          ser_out;
    logic [CW-1:0] bit_count;
    logic          frame_done;

    int total;
    int passed;
    int pulses;

    universal_shift_register #(
        .DATA_WIDTH (W),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .ser_in_msb(ser_in_msb),
        .ser_in_lsb(ser_in_lsb),
        .load_data (load_data),
        .data_out  (data_out),
        .ser_out   (ser_out),
        .bit_count (bit_count),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input logic [2:0] m,
                        input logic msb,
                        input logic lsb,
                        input logic [W-1:0] ld);
        mode       = m;
        ser_in_msb = msb;
        ser_in_lsb = lsb;
        load_data  = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_data"}, 32'(data_out), 32'h00);
        check({tag, "_ser"},  32'(ser_out), 32'h0);
        check({tag, "_cnt"},  32'(bit_count), 32'h0);
        check({tag, "_fd"},   32'(frame_done), 32'h0);
    endtask

    logic [7:0] pat;

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        mode   = M_LD;
        ser_in_msb = 1'b1;
        ser_in_lsb = 1'b1;
        load_data  = 8'hFF;

        // 1: reset before any clock edge, then hold through all modes
        #2;
        check_rst("rst0");
        for (int i = 0; i < 8; i++) step(3'(i), 1'b1, 1'b1, 8'hFF);
        check_rst("rst_modes");
        reset = 1'b0;

        // 2: eight SHIFT_R with 1,0,1,1,0,0,1,0
        pat = 8'b01001101;
        for (int i = 0; i < 8; i++) begin
            step(M_SR, pat[i], 1'b0, 8'h00);
            check($sformatf("sr_cnt%0d", i), 32'(bit_count),
                  32'((i + 1) % 8));
            check($sformatf("sr_fd%0d", i), 32'(frame_done),
                  32'(i == 7));
        end
        check("sr_data", 32'(data_out), 32'h4D);

        // 3: load, shift left, rotate right
        step(M_LD, 1'b0, 1'b0, 8'hA5);
        check("ld_data", 32'(data_out), 32'hA5);
        step(M_SL, 1'b0, 1'b0, 8'h00);
        check("sl_data", 32'(data_out), 32'h4A);
        check("sl_ser", 32'(ser_out), 32'h1);
        check("sl_cnt", 32'(bit_count), 32'h1);
        step(M_RR, 1'b0, 1'b0, 8'h00);
        check("rr_data", 32'(data_out), 32'h25);
        check("rr_ser", 32'(ser_out), 32'h1);
        check("rr_cnt", 32'(bit_count), 32'h1);
        step(M_RL, 1'b0, 1'b0, 8'h00);
        check("rl_data", 32'(data_out), 32'h4A);
        step(M_LD, 1'b0, 1'b0, 8'h81);
        step(M_RL, 1'b0, 1'b0, 8'h00);
        check("rl_wrap", 32'(data_out), 32'h03);
        step(M_LD, 1'b0, 1'b0, 8'h01);
        step(M_SR, 1'b0, 1'b0, 8'h00);
        check("sr_ser1", 32'(ser_out), 32'h1);
        check("sr_d1", 32'(data_out), 32'h00);
        step(M_SR, 1'b0, 1'b0, 8'h00);
        check("sr_ser0", 32'(ser_out), 32'h0);
        step(M_HOLD, 1'b1, 1'b1, 8'hFF);
        check("hold_ser", 32'(ser_out), 32'h0);
        check("hold_data", 32'(data_out), 32'h00);

        // 4: partial frame aborted by LOAD
        step(M_CLR, 1'b0, 1'b0, 8'h00);
        check("clr_cnt", 32'(bit_count), 32'h0);
        for (int i = 0; i < 5; i++) step(M_SR, 1'b1, 1'b0, 8'h00);
        check("part_cnt", 32'(bit_count), 32'h5);
        step(M_LD, 1'b0, 1'b0, 8'h3C);
        check("ab_data", 32'(data_out), 32'h3C);
        check("ab_cnt", 32'(bit_count), 32'h0);
        check("ab_fd", 32'(frame_done), 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(M_SL, 1'b0, 1'b1, 8'h00);
            if (frame_done) pulses++;
        end
        check("ab_fd8", 32'(frame_done), 32'h1);
        check("ab_pulses", 32'(pulses), 32'h1);
        check("ab_dfin", 32'(data_out), 32'hFF);
        step(M_CLR, 1'b0, 1'b0, 8'h00);
        check("clr_data", 32'(data_out), 32'h00);
        check("clr_fd", 32'(frame_done), 32'h0);

        // 5: continuous shifting, then reserved mode mid-stream
        for (int i = 0; i < 24; i++) begin
            step(M_SR, 1'(i & 1), 1'b0, 8'h00);
            check($sformatf("cont_fd%0d", i + 1), 32'(frame_done),
                  32'(i % 8 == 7));
        end
        step(M_CLR, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(M_SR, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step(M_RSV, 1'b0, 1'b0, 8'hFF);
            check("rsv_data", 32'(data_out), 32'hE0);
            check("rsv_cnt", 32'(bit_count), 32'h3);
            check("rsv_fd", 32'(frame_done), 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            step(M_SR, 1'b0, 1'b0, 8'h00);
            check("rsv_resume_fd", 32'(frame_done), 32'(i == 4));
        end

        // 6: async reset during shift 3 of a frame
        step(M_CLR, 1'b0, 1'b0, 8'h00);
        step(M_SR, 1'b1, 1'b0, 8'h00);
        step(M_SR, 1'b1, 1'b0, 8'h00);
        mode  = M_SR;
        reset = 1'b1;
        #1;
        check_rst("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(M_SR, 1'b1, 1'b0, 8'h00);
            check($sformatf("post_fd%0d", i), 32'(frame_done),
                  32'(i == 7));
        end
        check("post_data", 32'(data_out), 32'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
